// File: rtl/temp_sampler_pkg.sv
// Shared types and helpers for the temperature sampler.
// The raw-to-temperature conversion lives here so the top and any consumers agree on the format.
package temp_sampler_pkg;

  localparam int TEMP_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ
  } state_t;

  // 0.0625 degC/LSB: msb is the integer part, lsb[7:4] the fraction
  function automatic logic signed [TEMP_W-1:0] raw_to_temp(input logic [7:0] msb,
                                                           input logic [7:0] lsb);
    return {msb, lsb[7:4]};
  endfunction

endpackage

// File: rtl/temp_sampler_if.sv
// Request/response link between the sampler (master) and the I2C read engine (slave).
interface temp_sampler_if;
  logic       start;
  logic       done;
  logic [7:0] msb;
  logic [7:0] lsb;

  modport master (output start, input done, input msb, input lsb);
  modport slave  (input start, output done, output msb, output lsb);
endinterface

// File: rtl/temp_avg.sv
// Block averager: sums 2^AVG_LOG2 samples, then emits the floored mean for one cycle.
module temp_avg
  import temp_sampler_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic signed [TEMP_W-1:0] sample,
  input  logic                     sample_valid,
  output logic signed [TEMP_W-1:0] avg,
  output logic                     avg_valid
);

  localparam int ACC_W = TEMP_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_shr;
  logic        [CNT_W-1:0] cnt;

  // AVG_LOG2 extra bits absorb the full block of extreme samples without overflow
  assign sample_ext = ACC_W'(sample);
  assign acc_sum    = acc + sample_ext;
  assign acc_shr    = acc_sum >>> AVG_LOG2;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      acc       <= '0;
      cnt       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_valid) begin
        if (cnt == CNT_LAST) begin
          avg       <= acc_shr[TEMP_W-1:0];
          avg_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/temp_sampler.sv
// Periodic temperature acquisition: requests a read, captures msb/lsb, tracks min/max/average.
//   state | meaning
//   IDLE  | sampling disabled, waiting for en
//   WAIT  | period timer running down to the next request
//   REQ   | i2c start held, waiting for a done rising edge or the watchdog
module temp_sampler
  import temp_sampler_pkg::*;
#(
  parameter int PERIOD   = 1_000_000,
  parameter int TIMEOUT  = 200_000,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     en,
  input  logic                     err_clr,
  temp_sampler_if.master           i2c,
  output logic signed [TEMP_W-1:0] temp,
  output logic                     temp_valid,
  output logic signed [TEMP_W-1:0] avg,
  output logic                     avg_valid,
  output logic signed [TEMP_W-1:0] tmin,
  output logic signed [TEMP_W-1:0] tmax,
  output logic                     err
);

  localparam int TMR_MAX = (PERIOD > TIMEOUT) ? PERIOD : TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] PERIOD_LD  = TMR_W'(PERIOD - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT - 1);

  state_t                  state;
  logic [TMR_W-1:0]        tmr;
  logic                    done_q;
  logic                    first;
  logic                    done_rise;
  logic                    capture;
  logic                    tmo;
  logic signed [TEMP_W-1:0] sample;

  assign done_rise = i2c.done & ~done_q;
  assign sample    = raw_to_temp(i2c.msb, i2c.lsb);
  assign capture   = (state == REQ) && done_rise;
  // A completion on the last allowed cycle beats the watchdog
  assign tmo       = (state == REQ) && !done_rise && (tmr == '0);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state      <= IDLE;
      tmr        <= '0;
      done_q     <= 1'b0;
      first      <= 1'b1;
      i2c.start  <= 1'b0;
      temp       <= '0;
      temp_valid <= 1'b0;
      tmin       <= '0;
      tmax       <= '0;
      err        <= 1'b0;
    end else begin
      done_q     <= i2c.done;
      temp_valid <= 1'b0;

      if (tmo) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (en) begin
            state <= WAIT;
            tmr   <= PERIOD_LD;
          end
        end
        WAIT: begin
          if (!en) begin
            state <= IDLE;
          end else if (tmr == '0) begin
            state     <= REQ;
            i2c.start <= 1'b1;
            tmr       <= TIMEOUT_LD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        REQ: begin
          if (capture) begin
            temp       <= sample;
            temp_valid <= 1'b1;
            first      <= 1'b0;
            if (first || (sample < tmin)) tmin <= sample;
            if (first || (sample > tmax)) tmax <= sample;
          end
          // en only takes effect once the transaction has finished
          if (capture || tmo) begin
            i2c.start <= 1'b0;
            tmr       <= PERIOD_LD;
            state     <= en ? WAIT : IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          i2c.start <= 1'b0;
        end
      endcase
    end
  end

  temp_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .arst        (arst),
    .sample      (sample),
    .sample_valid(capture),
    .avg         (avg),
    .avg_valid   (avg_valid)
  );

endmodule

// File: doc/temp_sampler.md
# temp_sampler

Periodic acquisition controller sitting directly downstream of `i2c_fsm`. It issues the read request on `i2c_fsm.start` at a programmable rate and captures the `msb`/`lsb` pair when `done` rises. It converts the pair to a 12-bit signed temperature (0.0625 °C/LSB) and maintains a running block average plus min/max. A watchdog flags transactions that never complete.

## Interface
- `PERIOD`, default 1_000_000: cycles from end of one transaction to the next request (≥2).
- `TIMEOUT`, default 200_000: max cycles `i2c_start` may stay high without a `done` rising edge (≥2).
- `AVG_LOG2`, default 2: the average covers 2^AVG_LOG2 samples (0..4).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `arst`  in  1  asynchronous, active-low reset.
- `en`  in  1  sampling enable.
- `i2c_start`  out  1  request to `i2c_fsm`; level, held until done edge or timeout.
- `i2c_done`  in  1  `i2c_fsm.done`, level.
- `msb`  in  8  first byte read.
- `lsb`  in  8  second byte read.
- `temp`  out  12  last sample, signed, `{msb, lsb[7:4]}`.
- `temp_valid`  out  1  one-cycle pulse when `temp` updates.
- `avg`  out  12  signed block average.
- `avg_valid`  out  1  one-cycle pulse when `avg` updates.
- `tmin`, `tmax`  out  12 each  signed extremes since reset.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err`.

## Operation
- States: IDLE, WAIT, REQ.
  - IDLE: waits for `en`=1, then enters WAIT with the period counter cleared.
  - WAIT: counts to PERIOD-1, then enters REQ. `en`=0 in WAIT returns to IDLE immediately.
  - REQ: `i2c_start`=1.
- Done edge detection uses a registered `done_q`; a rising edge is `i2c_done & ~done_q`. A `done` level already high on entry to REQ is not a completion.
- Done edge while in REQ:
  - Capture `temp <= {msb, lsb[7:4]}` and pulse `temp_valid`.
  - Update min/max and the accumulator.
  - Drop `i2c_start` and go to WAIT, or to IDLE if `en`=0.
- Timeout: REQ lasting TIMEOUT cycles without an edge sets `err`, drops `i2c_start`, and goes to WAIT/IDLE with no sample. The accumulator is untouched.
- `en` deasserted during REQ does not abort; the transaction completes or times out first.
- Min/max: the first sample after reset loads both. After that, signed compare; equal values leave them unchanged.
- Average:
  - Accumulator is signed, 12+AVG_LOG2 bits, and cannot overflow.
  - When the 2^AVG_LOG2-th sample is added: `avg <= (acc + sample) >>> AVG_LOG2` (arithmetic, floor), pulse `avg_valid`, clear the accumulator and the sample counter.
  - AVG_LOG2=0 makes `avg` track `temp`.
- `err_clr` clears `err`. A timeout in the same cycle wins, so `err` stays 1.

## Timing
- Reset values: state IDLE, `i2c_start`=0, `temp`=0, `avg`=0, `tmin`=0, `tmax`=0, `temp_valid`=0, `avg_valid`=0, `err`=0, all counters 0, `done_q`=0, first-sample flag set.
- All outputs are registered.
- `i2c_start` rises on the clock edge PERIOD cycles after WAIT entry.
- Edge sampled at edge N (`i2c_done`=1, `done_q`=0):
  - Cycle N+1: `temp`, `tmin`, `tmax` and `avg` (if block complete) are updated, `temp_valid`/`avg_valid` are high, `i2c_start`=0.
- `msb`/`lsb` are sampled only at that edge. They must be stable while `done` is high.
- Timeout: `err` and `i2c_start`=0 are visible the cycle after the TIMEOUT-th REQ cycle.
- Reset asserted mid-REQ: all outputs return to reset values asynchronously. A partial accumulator is discarded.

## Structure
- `temp_sampler_pkg` holds:
  - `TEMP_W`=12;
  - the state enum (IDLE/WAIT/REQ);
  - function `raw_to_temp(msb, lsb)`.
- Sub-module `temp_avg` holds the accumulator, sample counter, shift and `avg_valid`. Its inputs are `clk`, `arst`, `sample`, `sample_valid`.
- The FSM, watchdog, min/max and done edge detect live in the top level.

## Test plan
- PERIOD=20, AVG_LOG2=0: model returns 0x19/0x00 → `i2c_start` rises 20 cycles after `en`. The cycle after the done edge shows `temp`=0x190 and a single-cycle `temp_valid`.
- Negative value: 0xE7/0x00 after 0x19/0x00 → `temp`=0xE70, `tmin`=0xE70, `tmax`=0x190.
- AVG_LOG2=2, samples 0x190, 0x190, 0x1A0, 0x1A1 → one `avg_valid` pulse, after the 4th sample only, with `avg`=0x198. Samples 0xFFF ×3 plus 0xFFE → `avg`=0xFFE (floor).
- TIMEOUT=50 with `i2c_done` stuck low → `err`=1 after 50 REQ cycles, `i2c_start`=0, no `temp_valid`, next request PERIOD later. Asserting `err_clr` in the same cycle as a second timeout keeps `err`=1.
- `i2c_done` already high when REQ is entered → no capture until it falls and rises again.
- `arst` low mid-REQ, or `en` dropped mid-REQ → reset: all outputs 0 immediately. `en` drop: the transaction completes with one `temp_valid`, then IDLE with no further `i2c_start`.
